// File: rtl/map_tile_state.sv
// map_tile_state
//   Writable Pacman playfield tile store. Each tile holds a 2-bit code:
//   00 empty, 01 pellet, 10 power pellet, 11 wall.
//   After reset or a restart pulse, an init sequencer builds the map one tile
//   per cycle. It queries the external wall LUT, scanning x in the outer loop
//   and y in the inner loop. The block then serves a registered render read
//   port and a single-cycle "eat" port, counts the pellets left and raises
//   level_clear once the board is empty.
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   restart              1-cycle pulse, rebuilds the map (new level)
//   wall_x/wall_y/wall_q wall LUT query (x folded when MIRROR=1) and its answer
//   rd_x/rd_y/rd_tile    render read, data one cycle after the address
//   eat_*                eat request/accept and the previous state of the tile
//   pellets_left         pellet + power tiles remaining
//   level_clear          board empty and init complete
//   init_busy            init sequencer running
module map_tile_state #(
  parameter int MAP_W  = 27,
  parameter int MAP_H  = 24,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int CNT_W  = 10,
  parameter int MIRROR = 1,
  parameter int PWR_X  = 2,
  parameter int PWR_Y0 = 3,
  parameter int PWR_Y1 = 18
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             restart,
  output logic [X_W-1:0]   wall_x,
  output logic [Y_W-1:0]   wall_y,
  input  logic             wall_q,
  input  logic [X_W-1:0]   rd_x,
  input  logic [Y_W-1:0]   rd_y,
  output logic [1:0]       rd_tile,
  input  logic             eat_valid,
  input  logic [X_W-1:0]   eat_x,
  input  logic [Y_W-1:0]   eat_y,
  output logic             eat_ready,
  output logic             eat_done,
  output logic [1:0]       eat_result,
  output logic [CNT_W-1:0] pellets_left,
  output logic             level_clear,
  output logic             init_busy
);

  localparam int N     = MAP_W * MAP_H;
  localparam int IDX_W = $clog2(N);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t             state_r, next_state_s;
  logic [1:0]         mem_r [0:N-1];
  logic [X_W-1:0]     scan_x_r;
  logic [Y_W-1:0]     scan_y_r;
  logic [CNT_W-1:0]   pellets_r;
  logic               level_clear_r, eat_done_r;
  logic [1:0]         eat_result_r, rd_tile_r;

  logic               scan_last_s, eat_in_range_s, rd_in_range_s;
  logic               eat_acc_s, eat_hit_s;
  logic [IDX_W-1:0]   init_idx_s, eat_idx_s, rd_idx_s;
  logic [1:0]         init_tile_s, eat_old_s;

  // Linear tile index, column-major (x * MAP_H + y); valid only for in-range x/y
  function automatic logic [IDX_W-1:0] tile_idx(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    logic [X_W+Y_W-1:0] t;
    t = ({{Y_W{1'b0}}, x} * (X_W+Y_W)'(MAP_H)) + {{X_W{1'b0}}, y};
    return t[IDX_W-1:0];
  endfunction

  // Initial tile code for one scan position, given the wall LUT answer
  function automatic logic [1:0] init_tile(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                           input logic wall);
    logic pwr_col, pwr_row;
    pwr_col = (x == X_W'(PWR_X)) || (x == X_W'(MAP_W-1-PWR_X));
    pwr_row = (y == Y_W'(PWR_Y0)) || (y == Y_W'(PWR_Y1));
    if (wall)                                          return 2'b11;
    else if (x == X_W'(0) || x == X_W'(MAP_W-1))       return 2'b00; // tunnel columns
    else if (pwr_col && pwr_row)                       return 2'b10;
    else                                               return 2'b01;
  endfunction

  // The wall LUT stores only the left half when mirrored, so the query x is folded
  assign wall_x = (MIRROR != 0 && scan_x_r > X_W'(MAP_W/2)) ? X_W'(MAP_W-1) - scan_x_r : scan_x_r;
  assign wall_y = scan_y_r;

  assign scan_last_s    = (scan_x_r == X_W'(MAP_W-1)) && (scan_y_r == Y_W'(MAP_H-1));
  assign init_tile_s    = init_tile(scan_x_r, scan_y_r, wall_q);
  assign init_idx_s     = tile_idx(scan_x_r, scan_y_r);

  assign eat_in_range_s = (eat_x < X_W'(MAP_W)) && (eat_y < Y_W'(MAP_H));
  assign eat_idx_s      = tile_idx(eat_x, eat_y);
  assign eat_old_s      = eat_in_range_s ? mem_r[eat_idx_s] : 2'b11;
  // An eat coinciding with restart is dropped
  assign eat_acc_s      = eat_valid && (state_r == ST_IDLE) && !restart;
  assign eat_hit_s      = eat_acc_s && eat_in_range_s && (eat_old_s == 2'b01 || eat_old_s == 2'b10);

  assign rd_in_range_s  = (rd_x < X_W'(MAP_W)) && (rd_y < Y_W'(MAP_H));
  assign rd_idx_s       = tile_idx(rd_x, rd_y);

  assign eat_ready      = (state_r == ST_IDLE);
  assign init_busy      = (state_r == ST_INIT);
  assign eat_done       = eat_done_r;
  assign eat_result     = eat_result_r;
  assign rd_tile        = rd_tile_r;
  assign pellets_left   = pellets_r;
  assign level_clear    = level_clear_r;

  // Next-state logic: restart wins from any state
  always_comb begin
    next_state_s = state_r;
    if (restart) begin
      next_state_s = ST_INIT;
    end else begin
      case (state_r)
        ST_INIT: next_state_s = scan_last_s ? ST_IDLE : ST_INIT;
        ST_IDLE: next_state_s = ST_IDLE;
        default: next_state_s = ST_INIT;
      endcase
    end
  end

  // State register and init scan pointer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_INIT;
      scan_x_r <= '0;
      scan_y_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (restart) begin
        scan_x_r <= '0;
        scan_y_r <= '0;
      end else if (state_r == ST_INIT) begin
        if (scan_y_r == Y_W'(MAP_H-1)) begin
          scan_y_r <= '0;
          scan_x_r <= scan_last_s ? X_W'(0) : scan_x_r + X_W'(1);
        end else begin
          scan_y_r <= scan_y_r + Y_W'(1);
        end
      end
    end
  end

  // Tile storage: init writes during the scan, eat clears pellet/power tiles.
  // The array is not reset because every entry is rewritten by the init scan.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem_r[init_idx_s] <= init_tile_s;
    end else if (eat_hit_s) begin
      mem_r[eat_idx_s] <= 2'b00;
    end
  end

  // Pellet counter, level clear flag and eat response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pellets_r     <= '0;
      level_clear_r <= 1'b0;
      eat_done_r    <= 1'b0;
      eat_result_r  <= 2'b00;
    end else begin
      eat_done_r <= eat_acc_s;
      if (eat_acc_s) begin
        eat_result_r <= eat_old_s;
      end
      if (restart) begin
        pellets_r     <= '0;
        level_clear_r <= 1'b0;
      end else begin
        level_clear_r <= (state_r == ST_IDLE) && (pellets_r == CNT_W'(0));
        if (state_r == ST_INIT && (init_tile_s == 2'b01 || init_tile_s == 2'b10)) begin
          pellets_r <= pellets_r + CNT_W'(1);
        end else if (eat_hit_s) begin
          pellets_r <= pellets_r - CNT_W'(1);
        end
      end
    end
  end

  // Render read port; a same-edge eat of the addressed tile is forwarded (write-first)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_tile_r <= 2'b00;
    end else if (state_r == ST_INIT) begin
      rd_tile_r <= 2'b00;
    end else if (!rd_in_range_s) begin
      rd_tile_r <= 2'b11;
    end else if (eat_hit_s && rd_idx_s == eat_idx_s) begin
      rd_tile_r <= 2'b00;
    end else begin
      rd_tile_r <= mem_r[rd_idx_s];
    end
  end

endmodule

// File: tb/tb_map_tile_state.sv
// tb_map_tile_state
//   Scoreboard bench for map_tile_state. A wall LUT model feeds the DUT and
//   a golden tile map tracks every eat. Expected eat results are queued when
//   an eat is driven and compared when eat_done appears.
module tb_map_tile_state;

  logic       clk = 1'b0;
  logic       resetn, restart;
  logic [7:0] wall_x, rd_x, eat_x;
  logic [6:0] wall_y, rd_y, eat_y;
  logic       wall_q;
  logic [1:0] rd_tile, eat_result;
  logic       eat_valid, eat_ready, eat_done, level_clear, init_busy;
  logic [9:0] pellets_left;

  int checks = 0;
  int failures = 0;
  int gold [0:26][0:23];
  int golden_cnt;
  int exp_pellets;
  int exp_q [$];

  map_tile_state dut (
    .clk(clk), .resetn(resetn), .restart(restart),
    .wall_x(wall_x), .wall_y(wall_y), .wall_q(wall_q),
    .rd_x(rd_x), .rd_y(rd_y), .rd_tile(rd_tile),
    .eat_valid(eat_valid), .eat_x(eat_x), .eat_y(eat_y),
    .eat_ready(eat_ready), .eat_done(eat_done), .eat_result(eat_result),
    .pellets_left(pellets_left), .level_clear(level_clear), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  // Left-half wall map (x in 0..13); column 0 is the open tunnel
  function automatic logic wall_fn(input int fx, input int fy);
    if (fx == 1) return 1'b1;
    if (fx >= 1 && (fy == 0 || fy == 23)) return 1'b1;
    if ((fx == 4 || fx == 8 || fx == 12) && (fy % 3 == 1)) return 1'b1;
    return 1'b0;
  endfunction

  assign wall_q = wall_fn(int'(wall_x), int'(wall_y));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic init_model();
    int fx;
    golden_cnt = 0;
    for (int x = 0; x < 27; x++) begin
      for (int y = 0; y < 24; y++) begin
        fx = (x > 13) ? 26 - x : x;
        if (wall_fn(fx, y))                              gold[x][y] = 3;
        else if (x == 0 || x == 26)                      gold[x][y] = 0;
        else if ((x == 2 || x == 24) && (y == 3 || y == 18)) gold[x][y] = 2;
        else                                             gold[x][y] = 1;
        if (gold[x][y] == 1 || gold[x][y] == 2) golden_cnt++;
      end
    end
    exp_pellets = golden_cnt;
  endtask

  // Scoreboard consumer: every eat_done pops one expected result
  always @(negedge clk) begin
    if (resetn && eat_done) begin
      if (exp_q.size() == 0) begin
        check_eq("eat_done_spurious", 32'(eat_done), 32'd0);
      end else begin
        check_eq("eat_result", 32'(eat_result), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (!init_busy) break;
    end
    check_eq(tag, 32'(n), 32'd648);
  endtask

  task automatic read_tile(input int x, input int y, input int exp, input string tag);
    @(negedge clk);
    rd_x = 8'(x); rd_y = 7'(y);
    @(posedge clk); #1;
    check_eq(tag, 32'(rd_tile), 32'(exp));
  endtask

  // Drive one eat for one cycle and queue its expected result
  task automatic do_eat(input int x, input int y);
    int e;
    @(negedge clk);
    eat_valid = 1'b1; eat_x = 8'(x); eat_y = 7'(y);
    if (x >= 27 || y >= 24) begin
      e = 3;
    end else begin
      e = gold[x][y];
      if (e == 1 || e == 2) begin
        gold[x][y] = 0;
        exp_pellets--;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic eat_stop();
    @(negedge clk);
    eat_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(init_busy), 32'd1);
    check_eq({tag, "_pellets"}, 32'(pellets_left), 32'd0);
    check_eq({tag, "_rd_tile"}, 32'(rd_tile), 32'd0);
    check_eq({tag, "_ready"}, 32'(eat_ready), 32'd0);
    check_eq({tag, "_done"}, 32'(eat_done), 32'd0);
    check_eq({tag, "_result"}, 32'(eat_result), 32'd0);
    check_eq({tag, "_clear"}, 32'(level_clear), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; restart = 1'b0; eat_valid = 1'b0;
    eat_x = '0; eat_y = '0; rd_x = '0; rd_y = '0;
    init_model();
    #1;
    check_reset_outputs("rst");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wait_init("init_cycles");
    check_eq("init_pellets", 32'(pellets_left), 32'(golden_cnt));
    check_eq("idle_ready", 32'(eat_ready), 32'd1);

    read_tile(0, 0, 0, "rd_0_0");
    read_tile(1, 0, 3, "rd_1_0");
    read_tile(2, 3, 2, "rd_2_3");
    read_tile(24, 18, 2, "rd_24_18");
    read_tile(5, 5, gold[5][5], "rd_5_5");
    read_tile(30, 5, 3, "rd_oor");

    // Single eats: power pellet, repeat, wall, out of range
    do_eat(2, 3);   eat_stop();
    check_eq("eat_pwr_cnt", 32'(pellets_left), 32'(exp_pellets));
    do_eat(2, 3);   eat_stop();
    do_eat(1, 0);   eat_stop();
    do_eat(30, 5);  eat_stop();
    @(negedge clk);
    check_eq("eat_misc_cnt", 32'(pellets_left), 32'(exp_pellets));
    read_tile(2, 3, 0, "rd_eaten");

    // Clear the board back-to-back
    for (int x = 0; x < 27; x++)
      for (int y = 0; y < 24; y++)
        if (gold[x][y] == 1 || gold[x][y] == 2) do_eat(x, y);
    eat_stop();
    check_eq("clear_cnt", 32'(pellets_left), 32'd0);
    check_eq("clear_early", 32'(level_clear), 32'd0);
    @(negedge clk);
    check_eq("level_clear", 32'(level_clear), 32'd1);
    do_eat(3, 3);   eat_stop();
    @(negedge clk);
    check_eq("no_underflow", 32'(pellets_left), 32'd0);

    // Restart with a simultaneous eat: the eat is dropped
    @(negedge clk);
    restart = 1'b1; eat_valid = 1'b1; eat_x = 8'd5; eat_y = 7'd5;
    @(negedge clk);
    restart = 1'b0; eat_valid = 1'b0;
    check_eq("rs_busy", 32'(init_busy), 32'd1);
    check_eq("rs_ready", 32'(eat_ready), 32'd0);
    check_eq("rs_pellets", 32'(pellets_left), 32'd0);
    check_eq("rs_clear", 32'(level_clear), 32'd0);
    init_model();
    wait_init("rs_init_cycles");
    check_eq("rs_init_pellets", 32'(pellets_left), 32'(golden_cnt));
    read_tile(2, 3, 2, "rs_rd_2_3");
    do_eat(5, 5);   eat_stop();

    // Reset in the middle of init
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    repeat (300) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    resetn = 1'b1;
    init_model();
    wait_init("midrst_init_cycles");
    check_eq("midrst_pellets", 32'(pellets_left), 32'(golden_cnt));
    read_tile(24, 18, 2, "midrst_rd_24_18");

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
